// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM wrapper between NUM_PORTS
// requesters. After reset it optionally zero-fills the array (INIT), then
// grants one access per cycle round-robin (RUN) and routes read data back
// to the port that issued the read.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_i/we_i          per-port request and write enable
//   addr_i/wdata_i/be_i per-port address, write data, byte enables
//   gnt_o               one-hot grant (combinational from req_i)
//   rvalid_o            per-port one-cycle read-response strobe
//   rdata_o             read data, broadcast, pass-through of sram_rdata_i
//   init_done_o         array usable
//   sram_*              SRAM wrapper request side / read data
module sram_port_arbiter #(
   parameter int unsigned NUM_PORTS  = 2,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned NUM_WORDS  = 256,
   parameter int unsigned READ_LAT   = 1,
   parameter int unsigned INIT_ZERO  = 1,
   localparam int unsigned AW = $clog2(NUM_WORDS),
   localparam int unsigned BW = (DATA_WIDTH + 7) / 8
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [NUM_PORTS-1:0]                  req_i,
   input  logic [NUM_PORTS-1:0]                  we_i,
   input  logic [NUM_PORTS-1:0][AW-1:0]          addr_i,
   input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
   input  logic [NUM_PORTS-1:0][BW-1:0]          be_i,
   output logic [NUM_PORTS-1:0]                  gnt_o,
   output logic [NUM_PORTS-1:0]                  rvalid_o,
   output logic [DATA_WIDTH-1:0]                 rdata_o,
   output logic                                  init_done_o,
   output logic                                  sram_req_o,
   output logic                                  sram_we_o,
   output logic [AW-1:0]                         sram_addr_o,
   output logic [DATA_WIDTH-1:0]                 sram_wdata_o,
   output logic [BW-1:0]                         sram_be_o,
   input  logic [DATA_WIDTH-1:0]                 sram_rdata_i
);

   localparam int unsigned PW = $clog2(NUM_PORTS);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e                       state_q;
   state_e                       state_d;
   logic [AW-1:0]                init_addr_q;
   logic [PW-1:0]                rr_ptr_q;
   logic [PW-1:0]                win_c;
   logic                         any_c;
   logic                         rd_issue_c;
   logic [READ_LAT-1:0]          rd_vld_q;
   logic [READ_LAT-1:0][PW-1:0]  rd_id_q;

   // Round-robin search starting at rr_ptr_q; first requester found wins.
   always_comb begin : arb
      int unsigned idx;
      idx   = 0;
      any_c = 1'b0;
      win_c = '0;
      gnt_o = '0;
      if (state_q == ST_RUN && !rst_i) begin
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = (32'(rr_ptr_q) + i) % NUM_PORTS;
            if (!any_c && req_i[PW'(idx)]) begin
               any_c = 1'b1;
               win_c = PW'(idx);
            end
         end
      end
      if (any_c) begin
         gnt_o[win_c] = 1'b1;
      end
   end

   // Next state and SRAM request mux; outputs are quiet while in reset.
   always_comb begin : ctrl
      state_d      = state_q;
      sram_req_o   = 1'b0;
      sram_we_o    = 1'b0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      sram_be_o    = '0;
      if (!rst_i) begin
         case (state_q)
            ST_INIT: begin
               sram_req_o  = 1'b1;
               sram_we_o   = 1'b1;
               sram_addr_o = init_addr_q;
               sram_be_o   = '1;
               if (init_addr_q == AW'(NUM_WORDS - 1)) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (any_c) begin
                  sram_req_o   = 1'b1;
                  sram_we_o    = we_i[win_c];
                  sram_addr_o  = addr_i[win_c];
                  sram_wdata_o = wdata_i[win_c];
                  sram_be_o    = be_i[win_c];
               end
            end
         endcase
      end
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Sweep address for the zero-fill
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         init_addr_q <= '0;
      end else if (state_q == ST_INIT) begin
         init_addr_q <= (init_addr_q == AW'(NUM_WORDS - 1)) ? '0 : init_addr_q + AW'(1);
      end
   end

   // Pointer moves just past the winner; holds when nothing is granted
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q <= '0;
      end else if (any_c) begin
         rr_ptr_q <= (win_c == PW'(NUM_PORTS - 1)) ? '0 : win_c + PW'(1);
      end
   end

   assign rd_issue_c = any_c && !we_i[win_c];

   // {valid, port id} travels alongside the SRAM read latency
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_vld_q <= '0;
         rd_id_q  <= '0;
      end else begin
         rd_vld_q[0] <= rd_issue_c;
         rd_id_q[0]  <= win_c;
         for (int unsigned s = 1; s < READ_LAT; s++) begin
            rd_vld_q[s] <= rd_vld_q[s-1];
            rd_id_q[s]  <= rd_id_q[s-1];
         end
      end
   end

   // Reset squashes a response already at the pipeline output
   always_comb begin : resp
      rvalid_o = '0;
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
         rvalid_o[k] = !rst_i && rd_vld_q[READ_LAT-1] && (rd_id_q[READ_LAT-1] == PW'(k));
      end
   end

   assign rdata_o     = sram_rdata_i;
   assign init_done_o = rst_i ? (INIT_ZERO == 0) : (state_q == ST_RUN);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: two arbiters (READ_LAT 1 and 2) share one stimulus stream,
// each in front of its own behavioural SRAM.
module tb_sram_port_arbiter;

   localparam logic [63:0] PAT = 64'hA5A5_A5A5_A5A5_A5A5;
   localparam logic [63:0] DBC = 64'hDEAD_BEEF_CAFE_F00D;
   localparam logic [63:0] A1  = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] A2  = 64'h0000_0000_FFFF_FFFF;

   logic clk = 1'b0;
   logic rst;
   logic [1:0]       req, we;
   logic [1:0][7:0]  addr;
   logic [1:0][63:0] wdata;
   logic [1:0][7:0]  be;

   logic [1:0]  gnt1, rvalid1, gnt2, rvalid2;
   logic [63:0] rdata1, rdata2;
   logic        done1, done2;
   logic        s1_req, s1_we, s2_req, s2_we;
   logic [7:0]  s1_addr, s2_addr, s1_be, s2_be;
   logic [63:0] s1_wdata, s2_wdata;
   logic [63:0] m1_rdata, m2_pipe, m2_rdata;
   logic [63:0] mem1 [256];
   logic [63:0] mem2 [256];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sram_port_arbiter #(.NUM_PORTS(2), .DATA_WIDTH(64), .NUM_WORDS(256), .READ_LAT(1), .INIT_ZERO(1)) u_d1 (
      .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
      .gnt_o(gnt1), .rvalid_o(rvalid1), .rdata_o(rdata1), .init_done_o(done1),
      .sram_req_o(s1_req), .sram_we_o(s1_we), .sram_addr_o(s1_addr), .sram_wdata_o(s1_wdata),
      .sram_be_o(s1_be), .sram_rdata_i(m1_rdata));

   sram_port_arbiter #(.NUM_PORTS(2), .DATA_WIDTH(64), .NUM_WORDS(256), .READ_LAT(2), .INIT_ZERO(1)) u_d2 (
      .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
      .gnt_o(gnt2), .rvalid_o(rvalid2), .rdata_o(rdata2), .init_done_o(done2),
      .sram_req_o(s2_req), .sram_we_o(s2_we), .sram_addr_o(s2_addr), .sram_wdata_o(s2_wdata),
      .sram_be_o(s2_be), .sram_rdata_i(m2_rdata));

   // Behavioural SRAMs; reset scribbles a non-zero pattern so the sweep must clear it
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) begin
            mem1[i] <= PAT;
            mem2[i] <= PAT;
         end
      end else begin
         if (s1_req && s1_we)
            for (int b = 0; b < 8; b++) if (s1_be[b]) mem1[s1_addr][b*8 +: 8] <= s1_wdata[b*8 +: 8];
         if (s1_req && !s1_we) m1_rdata <= mem1[s1_addr];
         if (s2_req && s2_we)
            for (int b = 0; b < 8; b++) if (s2_be[b]) mem2[s2_addr][b*8 +: 8] <= s2_wdata[b*8 +: 8];
         if (s2_req && !s2_we) m2_pipe <= mem2[s2_addr];
      end
      m2_rdata <= m2_pipe;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Grant pattern of the alternating-read window
   function automatic logic [1:0] exp_gnt(input int i);
      if (i < 0 || i > 3) return 2'b00;
      return (i % 2 == 0) ? 2'b10 : 2'b01;
   endfunction

   initial begin
      logic [1:0] r;
      rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; be = '0;
      m1_rdata = '0; m2_pipe = '0;

      // Reset cycle
      @(negedge clk);
      chk("rst_gnt", 64'(gnt1), 0);
      chk("rst_rvalid", 64'(rvalid1), 0);
      chk("rst_sram_req", 64'(s1_req), 0);
      chk("rst_done1", 64'(done1), 0);
      chk("rst_done2", 64'(done2), 0);

      // Port 1 write pending from before INIT
      req = 2'b10; we = 2'b10; addr[1] = 8'd9; wdata[1] = 64'h1111_2222_3333_4444; be[1] = 8'hFF;
      @(negedge clk);
      chk("rst_gnt_req", 64'(gnt1), 0);
      chk("rst_sram_req_req", 64'(s1_req), 0);
      tick();
      rst = 1'b0;

      // Zero-fill sweep
      for (int c = 0; c < 256; c++) begin
         @(negedge clk);
         chk($sformatf("init_req_%0d", c), 64'(s1_req), 1);
         chk($sformatf("init_we_%0d", c), 64'(s1_we), 1);
         chk($sformatf("init_addr_%0d", c), 64'(s1_addr), 64'(c));
         chk($sformatf("init_addr2_%0d", c), 64'(s2_addr), 64'(c));
         chk($sformatf("init_wdata_%0d", c), s1_wdata, 0);
         chk($sformatf("init_be_%0d", c), 64'(s1_be), 64'hFF);
         chk($sformatf("init_gnt_%0d", c), 64'({gnt2, gnt1}), 0);
         chk($sformatf("init_done_%0d", c), 64'(done1), 0);
         tick();
      end

      // Cycle 256: first RUN cycle grants the held port-1 write
      @(negedge clk);
      chk("run_done1", 64'(done1), 1);
      chk("run_done2", 64'(done2), 1);
      chk("run_gnt_p1", 64'(gnt1), 64'h2);
      chk("run_gnt_p1_d2", 64'(gnt2), 64'h2);
      chk("run_wr_addr", 64'(s1_addr), 9);
      chk("run_wr_we", 64'(s1_we), 1);
      chk("run_wr_data", s1_wdata, 64'h1111_2222_3333_4444);
      tick();

      // 257: read address 200
      req = 2'b01; we = 2'b00; addr[0] = 8'd200;
      @(negedge clk);
      chk("rd200_gnt", 64'(gnt1), 1);
      chk("rd200_we", 64'(s1_we), 0);
      chk("rd200_addr", 64'(s1_addr), 200);
      tick();

      // 258: write 5, single requester granted again
      we = 2'b01; addr[0] = 8'd5; wdata[0] = DBC; be[0] = 8'hFF;
      @(negedge clk);
      chk("wr5_gnt", 64'(gnt1), 1);
      chk("rd200_rvalid1", 64'(rvalid1), 1);
      chk("rd200_rdata1", rdata1, 0);
      chk("rd200_rvalid2_early", 64'(rvalid2), 0);
      tick();

      // 259: read 5
      we = 2'b00;
      @(negedge clk);
      chk("rd5_gnt", 64'(gnt1), 1);
      chk("wr5_no_rvalid1", 64'(rvalid1), 0);
      chk("rd200_rvalid2", 64'(rvalid2), 1);
      chk("rd200_rdata2", rdata2, 0);
      tick();

      // 260: idle, stale fields on the inputs must not leak
      req = 2'b00; we = 2'b01;
      @(negedge clk);
      chk("idle_gnt", 64'(gnt1), 0);
      chk("idle_req", 64'(s1_req), 0);
      chk("idle_we", 64'(s1_we), 0);
      chk("idle_addr", 64'(s1_addr), 0);
      chk("idle_wdata", s1_wdata, 0);
      chk("idle_be", 64'(s1_be), 0);
      chk("rd5_rvalid1", 64'(rvalid1), 1);
      chk("rd5_rdata1", rdata1, DBC);
      chk("rd5_rvalid2_early", 64'(rvalid2), 0);
      tick();

      // 261: both write; pointer sits at port 1
      req = 2'b11; we = 2'b11;
      addr[0] = 8'd1; wdata[0] = A1; be[0] = 8'hFF;
      addr[1] = 8'd2; wdata[1] = 64'hFFFF_FFFF_FFFF_FFFF; be[1] = 8'h0F;
      @(negedge clk);
      chk("wr2_gnt", 64'(gnt1), 2);
      chk("wr2_addr", 64'(s1_addr), 2);
      chk("wr2_be", 64'(s1_be), 64'h0F);
      chk("rd5_rvalid2", 64'(rvalid2), 1);
      chk("rd5_rdata2", rdata2, DBC);
      chk("wr2_rvalid1", 64'(rvalid1), 0);
      tick();

      // 262: port 0 write completes
      req = 2'b01;
      @(negedge clk);
      chk("wr1_gnt", 64'(gnt1), 1);
      chk("wr1_addr", 64'(s1_addr), 1);
      tick();

      // 263..268: both ports read continuously for four cycles, then drain
      for (int i = 0; i < 6; i++) begin
         if (i < 4) begin
            req = 2'b11; we = 2'b00; addr[0] = 8'd1; addr[1] = 8'd2;
         end else begin
            req = 2'b00;
         end
         @(negedge clk);
         chk($sformatf("rr_gnt1_%0d", i), 64'(gnt1), 64'(exp_gnt(i)));
         chk($sformatf("rr_gnt2_%0d", i), 64'(gnt2), 64'(exp_gnt(i)));
         r = exp_gnt(i - 1);
         chk($sformatf("rr_rvalid1_%0d", i), 64'(rvalid1), 64'(r));
         if (r != 2'b00) chk($sformatf("rr_rdata1_%0d", i), rdata1, (r == 2'b10) ? A2 : A1);
         r = exp_gnt(i - 2);
         chk($sformatf("rr_rvalid2_%0d", i), 64'(rvalid2), 64'(r));
         if (r != 2'b00) chk($sformatf("rr_rdata2_%0d", i), rdata2, (r == 2'b10) ? A2 : A1);
         tick();
      end

      // 269: read granted, then reset lands on the next cycle
      req = 2'b01; we = 2'b00; addr[0] = 8'd1;
      @(negedge clk);
      chk("pre_rst_gnt", 64'(gnt1), 1);
      tick();
      rst = 1'b1; req = 2'b00;
      @(negedge clk);
      chk("mid_rst_rvalid1", 64'(rvalid1), 0);
      chk("mid_rst_rvalid2", 64'(rvalid2), 0);
      chk("mid_rst_sram_req", 64'(s1_req), 0);
      chk("mid_rst_gnt", 64'(gnt1), 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_rvalid1", 64'(rvalid1), 0);
      chk("post_rst_rvalid2", 64'(rvalid2), 0);
      chk("post_rst_done", 64'(done1), 0);
      chk("post_rst_addr0", 64'(s1_addr), 0);
      chk("post_rst_we", 64'(s1_we), 1);
      tick();
      @(negedge clk);
      chk("post_rst_addr1", 64'(s1_addr), 1);
      chk("post_rst_rvalid2_late", 64'(rvalid2), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
